c17_pipe: RTL and testbench



---
 rtl/c17_pipe.sv | 110 +++++++++++
 tb/tb_c17_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/c17_pipe.sv
// Pipelined, flow-controlled ISCAS c17 evaluator over WIDTH independent bit lanes.
// PIPE=2 splits after the N10/N16/N19 level; PIPE=1 keeps only the output register.
module c17_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PIPE  = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] N1,
  input  logic [WIDTH-1:0] N2,
  input  logic [WIDTH-1:0] N3,
  input  logic [WIDTH-1:0] N6,
  input  logic [WIDTH-1:0] N7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] N22,
  output logic [WIDTH-1:0] N23,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic             v2_q;
  logic [WIDTH-1:0] n22_q, n23_q;
  logic             ready2;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_n22, s2_n23;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // First NAND levels, shared by both stage splits.
  logic [WIDTH-1:0] n10, n11, n16, n19;
  assign n10 = ~(N1 & N3);
  assign n11 = ~(N3 & N6);
  assign n16 = ~(N2 & n11);
  assign n19 = ~(n11 & N7);

  assign ready2 = ~v2_q | out_ready;

  if (PIPE == 2) begin : g_two_stage
    logic             v1_q;
    logic [WIDTH-1:0] n10_q, n16_q, n19_q;
    logic             ready1;

    assign ready1   = ~v1_q | ready2;
    assign in_ready = ready1;

    // NOTE: data flops are reset too, so the outputs read 0 after reset rather than X.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v1_q  <= 1'b0;
        n10_q <= '0;
        n16_q <= '0;
        n19_q <= '0;
      end else if (ready1) begin
        v1_q  <= in_valid;
        n10_q <= n10;
        n16_q <= n16;
        n19_q <= n19;
      end
    end

    assign s2_valid = v1_q;
    assign s2_n22   = ~(n10_q & n16_q);
    assign s2_n23   = ~(n16_q & n19_q);
  end else begin : g_one_stage
    assign in_ready = ready2;
    assign s2_valid = in_valid;
    assign s2_n22   = ~(n10 & n16);
    assign s2_n23   = ~(n16 & n19);
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q  <= 1'b0;
      n22_q <= '0;
      n23_q <= '0;
    end else if (ready2) begin
      v2_q  <= s2_valid;
      n22_q <= s2_n22;
      n23_q <= s2_n23;
    end
  end

  // Clear wins over a simultaneous transfer.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (v2_q && out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = v2_q;
  assign N22       = n22_q;
  assign N23       = n23_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_c17_pipe.sv
// Self-checking bench for c17_pipe: directed table, random stream against a
// boolean reference model, backpressure, counter wrap/clear and a PIPE=1 build.
module tb_c17_pipe;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1, cnt_clr = 1'b0;
  logic [W-1:0] n1 = '0, n2 = '0, n3 = '0, n6 = '0, n7 = '0;

  logic in_ready, out_valid;
  logic [W-1:0] n22, n23;
  logic [15:0] xfer_cnt;

  logic in_ready_w, out_valid_w;
  logic [W-1:0] n22_w, n23_w;
  logic [2:0] xfer_cnt_w;

  logic p1_in_valid = 1'b0, p1_out_ready = 1'b1;
  logic p1_in_ready, p1_out_valid;
  logic [W-1:0] p1_n22, p1_n23;
  logic [15:0] p1_xfer_cnt;

  int checks = 0;
  int failures = 0;
  int sent = 0;
  int cnt_m = 0;
  logic [2*W-1:0] exp_q[$];

  always #5 clk = ~clk;

  c17_pipe #(.WIDTH(W), .PIPE(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .N1(n1), .N2(n2), .N3(n3), .N6(n6), .N7(n7),
    .out_valid(out_valid), .out_ready(out_ready), .N22(n22), .N23(n23),
    .cnt_clr(cnt_clr), .xfer_cnt(xfer_cnt));

  c17_pipe #(.WIDTH(W), .PIPE(2), .CNT_W(3)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .N1(n1), .N2(n2), .N3(n3), .N6(n6), .N7(n7),
    .out_valid(out_valid_w), .out_ready(out_ready), .N22(n22_w), .N23(n23_w),
    .cnt_clr(cnt_clr), .xfer_cnt(xfer_cnt_w));

  c17_pipe #(.WIDTH(W), .PIPE(1), .CNT_W(16)) u_dut_p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(p1_in_valid), .in_ready(p1_in_ready),
    .N1(n1), .N2(n2), .N3(n3), .N6(n6), .N7(n7),
    .out_valid(p1_out_valid), .out_ready(p1_out_ready), .N22(p1_n22), .N23(p1_n23),
    .cnt_clr(cnt_clr), .xfer_cnt(p1_xfer_cnt));

  // Sum-of-products form of c17: N22 = N1N3 + N2~(N3N6), N23 = ~(N3N6)(N2+N7).
  function automatic logic [2*W-1:0] c17_ref(input logic [W-1:0] a1, a2, a3, a6, a7);
    logic [W-1:0] o22, o23;
    o22 = (a1 & a3) | (a2 & ~(a3 & a6));
    o23 = ~(a3 & a6) & (a2 | a7);
    return {o22, o23};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_vec();
    n1 = W'($urandom); n2 = W'($urandom); n3 = W'($urandom);
    n6 = W'($urandom); n7 = W'($urandom);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Scoreboard: inputs and outputs sampled mid-cycle, for the edge that follows.
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        check("out_has_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("stream_n22", n22, e[2*W-1:W]);
          check("stream_n23", n23, e[W-1:0]);
          check("w_valid", out_valid_w, 1);
          check("w_n22", n22_w, e[2*W-1:W]);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(c17_ref(n1, n2, n3, n6, n7));
        sent++;
      end
      if (cnt_clr) cnt_m = 0;
      else if (out_valid && out_ready) cnt_m++;
    end
  end

  typedef struct {
    logic [W-1:0] a1, a2, a3, a6, a7;
    logic [W-1:0] e22, e23;
  } vec_t;

  vec_t tbl[3];
  int base;
  logic [2*W-1:0] pv;

  initial begin
    tbl[0] = '{a1: 8'hFF, a2: 8'hFF, a3: 8'hFF, a6: 8'hFF, a7: 8'hFF, e22: 8'hFF, e23: 8'h00};
    tbl[1] = '{a1: 8'h00, a2: 8'h00, a3: 8'h00, a6: 8'h00, a7: 8'h00, e22: 8'h00, e23: 8'h00};
    tbl[2] = '{a1: 8'h00, a2: 8'hFF, a3: 8'hFF, a6: 8'h00, a7: 8'hFF, e22: 8'hFF, e23: 8'hFF};

    // Reset state.
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_n22", n22, 0);
    check("rst_n23", n23, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_xfer_cnt", xfer_cnt, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Reset mid-stream with vectors in flight.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_vec(); n1 = 8'hFF; n3 = 8'hFF;
      out_ready = (i < 2);
      step();
    end
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    cnt_m = 0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_n22", n22, 0);
    check("midrst_n23", n23, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_xfer_cnt", xfer_cnt, 0);
    in_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_out_valid", out_valid, 0);
    end
    check("idle_xfer_cnt", xfer_cnt, 0);
    check("idle_in_ready", in_ready, 1);

    // Directed single vectors with latency check.
    for (int i = 0; i < 3; i++) begin
      n1 = tbl[i].a1; n2 = tbl[i].a2; n3 = tbl[i].a3; n6 = tbl[i].a6; n7 = tbl[i].a7;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("tbl_lat1_valid", out_valid, 0);
      step();
      check("tbl_lat2_valid", out_valid, 1);
      check("tbl_n22", n22, tbl[i].e22);
      check("tbl_n23", n23, tbl[i].e23);
      step();
      check("tbl_after_valid", out_valid, 0);
      check("tbl_hold_n22", n22, tbl[i].e22);
    end

    // Random stream with random backpressure.
    base = sent;
    for (int c = 0; c < 2000 && sent - base < 200; c++) begin
      rand_vec();
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      step();
    end
    check("rand_sent", sent - base, 200);
    drain();

    // Backpressure: full pipeline stalled for 5 cycles.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    base = sent;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin rand_vec(); step(); end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_vec();
      #1;
      check("stall_in_ready", in_ready, 0);
      check("stall_in_ready_w", in_ready_w, 0);
      step();
      check("stall_out_valid", out_valid, 1);
      if (exp_q.size() != 0) begin
        pv = exp_q[0];
        check("stall_n22", n22, pv[2*W-1:W]);
        check("stall_n23", n23, pv[W-1:0]);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin rand_vec(); step(); end
    drain();
    check("bp_xfer_cnt", xfer_cnt, 32'(sent - base));
    check("bp_cnt_model", xfer_cnt, cnt_m[15:0]);

    // Counter wrap on the CNT_W=3 build.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin rand_vec(); step(); end
    drain();
    check("wrap_cnt16", xfer_cnt, 9);
    check("wrap_cnt3", xfer_cnt_w, 1);

    // Clear coincident with a transfer.
    rand_vec();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("clr_pre_valid", out_valid, 1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_cnt16", xfer_cnt, 0);
    check("clr_cnt3", xfer_cnt_w, 0);
    check("clr_out_valid", out_valid, 0);
    check("clr_queue", exp_q.size(), 0);

    // PIPE=1 build: one-cycle latency and full throughput.
    n1 = 8'hFF; n2 = 8'hFF; n3 = 8'hFF; n6 = 8'hFF; n7 = 8'hFF;
    p1_out_ready = 1'b1;
    p1_in_valid = 1'b1;
    step();
    check("p1_valid", p1_out_valid, 1);
    check("p1_n22", p1_n22, 8'hFF);
    check("p1_n23", p1_n23, 8'h00);
    for (int i = 0; i < 6; i++) begin
      rand_vec();
      pv = c17_ref(n1, n2, n3, n6, n7);
      #1;
      check("p1_in_ready", p1_in_ready, 1);
      step();
      check("p1_tp_valid", p1_out_valid, 1);
      check("p1_tp_n22", p1_n22, pv[2*W-1:W]);
      check("p1_tp_n23", p1_n23, pv[W-1:0]);
    end
    p1_in_valid = 1'b0;
    step();
    check("p1_idle_valid", p1_out_valid, 0);
    check("p1_xfer_cnt", p1_xfer_cnt, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
